// File: rtl/hci_core_mem_responder.sv
// hci_core_mem_responder
//   HCI core target-side responder: a word-addressed SRAM bank that accepts
//   req/gnt transactions and returns in-order r_valid/r_ready responses after
//   a fixed LATENCY, with a credit-limited number of outstanding transactions.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync flush)
//   req_i/gnt_o, add_i (byte address), wen_i (1=read), be_i, data_i, user_i, id_i
//   r_data_o ('0 for writes), r_valid_o/r_ready_i, r_user_o, r_id_o
module hci_core_mem_responder #(
    parameter int unsigned DW             = 32,
    parameter int unsigned AW             = 32,
    parameter int unsigned UW             = 1,
    parameter int unsigned IW             = 8,
    parameter int unsigned NB_WORDS       = 1024,
    parameter int unsigned LATENCY        = 1,
    parameter int unsigned RSP_FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [AW-1:0]   add_i,
    input  logic            wen_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   data_i,
    input  logic [UW-1:0]   user_i,
    input  logic [IW-1:0]   id_i,
    output logic [DW-1:0]   r_data_o,
    output logic            r_valid_o,
    input  logic            r_ready_i,
    output logic [UW-1:0]   r_user_o,
    output logic [IW-1:0]   r_id_o
);

    localparam int unsigned NBE  = DW / 8;
    localparam int unsigned OFFW = $clog2(NBE);
    localparam int unsigned IDXW = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam int unsigned CW   = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int unsigned PW   = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be >= 1");
    end
    if (RSP_FIFO_DEPTH < 1) begin : g_bad_depth
        $error("RSP_FIFO_DEPTH must be >= 1");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("DW must be a multiple of 8");
    end
    if ((NB_WORDS & (NB_WORDS - 1)) != 0) begin : g_bad_words
        $error("NB_WORDS must be a power of 2");
    end

    logic [DW-1:0]   mem [NB_WORDS];
    logic [IDXW-1:0] idx;
    logic            txn;
    logic            pop;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   in_data;

    logic            push_v;
    logic [DW-1:0]   push_d;
    logic [UW-1:0]   push_u;
    logic [IW-1:0]   push_id;

    logic [DW-1:0]   fifo_d  [RSP_FIFO_DEPTH];
    logic [UW-1:0]   fifo_u  [RSP_FIFO_DEPTH];
    logic [IW-1:0]   fifo_id [RSP_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   occ;

    // Byte-offset and upper address bits are intentionally ignored (aliasing).
    logic unused_add;
    assign unused_add = ^add_i;

    assign idx     = add_i[OFFW +: IDXW];
    assign gnt_o   = req_i & ~clear_i & ~rst_i & (cnt < CW'(RSP_FIFO_DEPTH));
    assign txn     = req_i & gnt_o;
    assign in_data = wen_i ? mem[idx] : '0;
    assign pop     = r_valid_o & r_ready_i;

    always_ff @(posedge clk_i) begin
        if (txn && !wen_i) begin
            for (int unsigned b = 0; b < NBE; b++) begin
                if (be_i[b]) mem[idx][8*b +: 8] <= data_i[8*b +: 8];
            end
        end
    end

    // Delay line of LATENCY-1 stages; with LATENCY=1 the granted entry goes
    // straight into the FIFO so it is at the head one cycle after grant.
    if (LATENCY > 1) begin : g_pipe
        logic [LATENCY-2:0] pv;
        logic [DW-1:0]      pd  [LATENCY-1];
        logic [UW-1:0]      pu  [LATENCY-1];
        logic [IW-1:0]      pid [LATENCY-1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pv <= '0;
            end else if (clear_i) begin
                pv <= '0;
            end else begin
                pv[0] <= txn;
                for (int unsigned i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            pd[0]  <= in_data;
            pu[0]  <= user_i;
            pid[0] <= id_i;
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                pd[i]  <= pd[i-1];
                pu[i]  <= pu[i-1];
                pid[i] <= pid[i-1];
            end
        end

        assign push_v  = pv[LATENCY-2];
        assign push_d  = pd[LATENCY-2];
        assign push_u  = pu[LATENCY-2];
        assign push_id = pid[LATENCY-2];
    end else begin : g_nopipe
        assign push_v  = txn;
        assign push_d  = in_data;
        assign push_u  = user_i;
        assign push_id = id_i;
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_v) begin
            fifo_d[wr_ptr]  <= push_d;
            fifo_u[wr_ptr]  <= push_u;
            fifo_id[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_v) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            case ({push_v, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    // Credits cover pipeline + FIFO, so the FIFO can never overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clear_i) begin
            cnt <= '0;
        end else begin
            case ({txn, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign r_valid_o = (occ != '0);

    always_comb begin
        r_data_o = '0;
        r_user_o = '0;
        r_id_o   = '0;
        if (r_valid_o) begin
            r_data_o = fifo_d[rd_ptr];
            r_user_o = fifo_u[rd_ptr];
            r_id_o   = fifo_id[rd_ptr];
        end
    end

endmodule

// File: tb/tb_hci_core_mem_responder.sv
module tb_hci_core_mem_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned UW    = 2;
    localparam int unsigned IW    = 8;
    localparam int unsigned NBW   = 64;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 3;

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            clear_i = 1'b0;
    logic            req_i = 1'b0;
    logic            gnt_o;
    logic [AW-1:0]   add_i = '0;
    logic            wen_i = 1'b1;
    logic [DW/8-1:0] be_i = '0;
    logic [DW-1:0]   data_i = '0;
    logic [UW-1:0]   user_i = '0;
    logic [IW-1:0]   id_i = '0;
    logic [DW-1:0]   r_data_o;
    logic            r_valid_o;
    logic            r_ready_i = 1'b0;
    logic [UW-1:0]   r_user_o;
    logic [IW-1:0]   r_id_o;

    hci_core_mem_responder #(
        .DW(DW), .AW(AW), .UW(UW), .IW(IW), .NB_WORDS(NBW),
        .LATENCY(LAT), .RSP_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .data_i(data_i), .user_i(user_i), .id_i(id_i),
        .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .r_user_o(r_user_o), .r_id_o(r_id_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [IW-1:0] id;
        int            k;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] mm [NBW];
    int            cyc = 0;
    int            last_pop = -100;
    int            checks = 0;
    int            passed = 0;
    int            ready_mode = 0;   // 0 low, 1 high, 2 random

    task automatic check(input bit ok, input string name, input string info);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: %s (t=%0t)", name, info, $time);
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a / (DW / 8)) % NBW);
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       r_ready_i = 1'b0;
            1:       r_ready_i = 1'b1;
            default: r_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: predicted grant and response timing from outstanding count and
    // per-entry grant cycle; compares head contents whenever a response shows.
    always @(negedge clk) begin
        bit pg;
        bit pv;
        pg = req_i && !clear_i && !rst_i && (q.size() < DEPTH);
        check(gnt_o === pg, "gnt", $sformatf("got %b want %b", gnt_o, pg));
        pv = (q.size() > 0) && !rst_i && (cyc >= q[0].k + int'(LAT)) && (cyc > last_pop);
        check(r_valid_o === pv, "r_valid", $sformatf("got %b want %b", r_valid_o, pv));
        if (pv && r_valid_o) begin
            check(r_data_o === q[0].d && r_id_o === q[0].id && r_user_o === q[0].u, "rsp",
                  $sformatf("got d=%h id=%0d u=%0d want d=%h id=%0d u=%0d",
                            r_data_o, r_id_o, r_user_o, q[0].d, q[0].id, q[0].u));
        end
        if (pv && r_ready_i) begin
            void'(q.pop_front());
            last_pop = cyc;
        end
    end

    // Recorder: on every grant, compute the expected response from the model.
    always @(negedge clk) begin
        rsp_t e;
        int   i;
        #1;
        if (clear_i) q.delete();
        if (req_i && gnt_o) begin
            i    = widx(add_i);
            e.u  = user_i;
            e.id = id_i;
            e.k  = cyc;
            if (wen_i) begin
                e.d = mm[i];
            end else begin
                e.d = '0;
                for (int b = 0; b < DW / 8; b++)
                    if (be_i[b]) mm[i][8*b +: 8] = data_i[8*b +: 8];
            end
            q.push_back(e);
        end
    end

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW/8-1:0] be,
                        input logic [DW-1:0] d, input logic [IW-1:0] id, output int gc);
        int n;
        req_i = 1'b1; wen_i = w; add_i = a; be_i = be; data_i = d; id_i = id;
        user_i = UW'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_o && n < 300);
        gc = cyc;
        if (!gnt_o) check(1'b0, "grant_timeout", $sformatf("no grant within %0d cycles", n));
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        ready_mode = 1;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check(q.size() == 0, "drain", $sformatf("%0d responses still pending", q.size()));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int gc;
        int g0;
        int g1;
        int grants;
        logic [IW-1:0] nid;

        #1 rst_i = 1'b1;
        req_i = 1'b1;
        @(negedge clk); @(negedge clk);
        check(gnt_o === 1'b0 && r_valid_o === 1'b0, "reset_hs",
              $sformatf("got gnt=%b valid=%b want 0/0", gnt_o, r_valid_o));
        check(r_data_o === '0 && r_id_o === '0 && r_user_o === '0, "reset_data",
              $sformatf("got d=%h id=%h u=%h want zeros", r_data_o, r_id_o, r_user_o));
        @(posedge clk); #1;
        req_i = 1'b0; rst_i = 1'b0;
        ready_mode = 1;

        for (int i = 0; i < int'(NBW); i++)
            send(1'b0, AW'(i * 4), '1, DW'($urandom), IW'(i), gc);

        // Write then read the same word
        send(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 8'd3, gc);
        send(1'b1, 32'h10, 4'h0, 32'h0, 8'd5, gc);
        drain();

        // Partial byte-enable write and upper-address aliasing
        send(1'b0, 32'h20, 4'hF, 32'h11223344, 8'd10, gc);
        send(1'b0, 32'h20, 4'b0010, 32'h0000AB00, 8'd11, gc);
        send(1'b1, 32'h20, 4'h0, 32'h0, 8'd12, gc);
        send(1'b1, 32'h20 + NBW * 4, 4'h0, 32'h0, 8'd13, gc);
        send(1'b1, 32'h22, 4'h0, 32'h0, 8'd14, gc);
        drain();

        // Credit exhaustion with r_ready low, then release
        ready_mode = 0;
        idle(1);
        grants = 0;
        nid = 8'd40;
        req_i = 1'b1; wen_i = 1'b1; add_i = 32'h44; id_i = nid;
        repeat (8) begin
            bit g;
            @(negedge clk);
            g = gnt_o;
            @(posedge clk); #1;
            if (g) begin
                grants++;
                nid++;
                id_i = nid;
            end
        end
        check(grants == int'(DEPTH), "credit_limit", $sformatf("got %0d grants want %0d", grants, DEPTH));
        ready_mode = 1;
        repeat (8) begin
            bit g;
            @(negedge clk);
            g = gnt_o;
            @(posedge clk); #1;
            if (g) begin
                nid++;
                id_i = nid;
            end
        end
        req_i = 1'b0;
        drain();

        // Back-to-back reads at full throughput
        ready_mode = 1;
        g0 = 0;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, AW'($urandom), '0, '0, IW'(100 + i), gc);
            if (i == 0) g0 = gc;
            g1 = gc;
        end
        check(g1 - g0 == 15, "b2b_grants", $sformatf("got span %0d want 15", g1 - g0));
        drain();

        // Synchronous clear drops in-flight reads
        ready_mode = 0;
        send(1'b1, 32'h10, '0, '0, 8'd200, gc);
        send(1'b1, 32'h20, '0, '0, 8'd201, gc);
        idle(LAT + 1);
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
        @(negedge clk);
        check(r_valid_o === 1'b0, "clear_valid", $sformatf("got %b want 0", r_valid_o));
        @(posedge clk); #1;
        ready_mode = 1;
        send(1'b1, 32'h10, '0, '0, 8'd202, gc);
        drain();

        // Asynchronous reset while a response is pending
        ready_mode = 0;
        send(1'b1, 32'h30, '0, '0, 8'd210, gc);
        send(1'b1, 32'h34, '0, '0, 8'd211, gc);
        idle(LAT + 1);
        req_i = 1'b1; wen_i = 1'b1; add_i = 32'h38; id_i = 8'd212;
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        check(gnt_o === 1'b0 && r_valid_o === 1'b0, "async_reset",
              $sformatf("got gnt=%b valid=%b want 0/0", gnt_o, r_valid_o));
        q.delete();
        req_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;
        ready_mode = 1;
        send(1'b1, 32'h10, '0, '0, 8'd213, gc);
        drain();

        // Randomised traffic with random back-pressure and occasional clears
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 50) == 0) begin
                clear_i = 1'b1;
                idle(1);
                clear_i = 1'b0;
            end
            send(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), IW'($urandom), gc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, checks);
        $fatal(1);
    end

endmodule
